// File: rtl/tiny_mcu_pkg.sv
// Shared types and constants for the SPI memory controller: FSM states,
// SPI command bytes and field lengths.
package tiny_mcu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_WRITE     = 8'h02;

  localparam int CMD_BITS   = 8;
  localparam int DUMMY_BITS = 8;
  localparam int DATA_BITS  = 8;

  function automatic logic [7:0] read_cmd();
`ifdef SPI_MEM_FAST_READ_EN
    return CMD_FAST_READ;
`else
    return CMD_READ;
`endif
  endfunction

endpackage

// File: rtl/spi_mem_shifter.sv
// Byte shift register for the SPI datapath: parallel load, then one shift per
// SPI bit that advances the outgoing MSB and samples MISO into the LSB.
module spi_mem_shifter
  import tiny_mcu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 miso,
  output logic                 msb_next,
  output logic [DATA_BITS-1:0] rx_next
);

  logic [DATA_BITS-1:0] sr_q, sr_d;

  // Load has priority over shift; otherwise hold
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift) begin
      sr_d = {sr_q[DATA_BITS-2:0], miso};
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= 8'h00;
    end else begin
      sr_q <= sr_d;
    end
  end

  // msb_next is what MOSI will carry in the coming phase A
  assign msb_next = sr_d[DATA_BITS-1];
  assign rx_next  = {sr_q[DATA_BITS-2:0], miso};

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 master (sclk = clk/2) serving byte reads/writes to SPI flash and PSRAM.
// Define SPI_MEM_FAST_READ_EN to issue 0x0B reads with 8 dummy bits.
module spi_mem_ctrl #(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_psram,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              resp_valid,
  output logic [7:0]        resp_rdata,
  output logic              resp_err,
  output logic              sclk_out,
  output logic              flash_cs_out,
  output logic              psram_cs_out,
  output logic              mosi_out,
  input  logic              miso_in
);
  import tiny_mcu_pkg::*;

  localparam logic [5:0] CNT_CMD   = 6'(CMD_BITS - 1);
  localparam logic [5:0] CNT_ADDR  = 6'(ADDR_W - 1);
  localparam logic [5:0] CNT_DUMMY = 6'(DUMMY_BITS - 1);
  localparam logic [5:0] CNT_BYTE  = 6'(DATA_BITS - 1);

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              psram_q, psram_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic       sclk_q, sclk_d;
  logic       flash_cs_q, flash_cs_d;
  logic       psram_cs_q, psram_cs_d;
  logic       mosi_q, mosi_d;
  logic       ready_q, ready_d;
  logic       resp_valid_q, resp_valid_d;
  logic       resp_err_q, resp_err_d;
  logic [7:0] resp_rdata_q, resp_rdata_d;

  logic       busy_d;
  logic       err_set;
  logic       rd_capture;
  logic       sh_load;
  logic       sh_shift;
  logic [7:0] sh_load_data;
  logic       sh_msb_next;
  logic [7:0] sh_rx_next;

  // Address is sent a byte at a time; ADDR_W is expected to be a multiple of 8
  function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] a, input logic [5:0] top);
    return 8'(a >> (top - 6'd7));
  endfunction

  spi_mem_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (sh_load_data),
    .miso      (miso_in),
    .msb_next  (sh_msb_next),
    .rx_next   (sh_rx_next)
  );

  // FSM next state, bit counter and shifter control
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    psram_d      = psram_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    sh_load_data = 8'h00;
    err_set      = 1'b0;
    rd_capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          psram_d = req_psram;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (!req_psram && req_we) begin
            state_d = ST_DONE;
            err_set = 1'b1;
          end else begin
            state_d      = ST_CMD;
            phase_d      = PH_A;
            cnt_d        = CNT_CMD;
            sh_load      = 1'b1;
            sh_load_data = req_we ? CMD_WRITE : read_cmd();
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
        if (phase_q == PH_A) begin
          phase_d = PH_B;
        end else if (cnt_q != 6'd0) begin
          phase_d = PH_A;
          cnt_d   = cnt_q - 6'd1;
          // Reload the next address byte on each byte boundary
          if ((state_q == ST_ADDR) && (cnt_q[2:0] == 3'd0)) begin
            sh_load      = 1'b1;
            sh_load_data = addr_byte(addr_q, cnt_q - 6'd1);
          end else begin
            sh_shift = (state_q != ST_DUMMY);
          end
        end else begin
          phase_d = PH_A;
          case (state_q)
            ST_CMD: begin
              state_d      = ST_ADDR;
              cnt_d        = CNT_ADDR;
              sh_load      = 1'b1;
              sh_load_data = addr_byte(addr_q, CNT_ADDR);
            end
            ST_ADDR: begin
              cnt_d   = CNT_BYTE;
              sh_load = 1'b1;
`ifdef SPI_MEM_FAST_READ_EN
              if (we_q) begin
                state_d      = ST_DATA;
                sh_load_data = wdata_q;
              end else begin
                state_d      = ST_DUMMY;
                cnt_d        = CNT_DUMMY;
                sh_load_data = 8'h00;
              end
`else
              state_d      = ST_DATA;
              sh_load_data = we_q ? wdata_q : 8'h00;
`endif
            end
            ST_DUMMY: begin
              state_d      = ST_DATA;
              cnt_d        = CNT_BYTE;
              sh_load      = 1'b1;
              sh_load_data = 8'h00;
            end
            ST_DATA: begin
              state_d    = ST_DONE;
              sh_shift   = 1'b1;
              rd_capture = !we_q;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin and response values for the next cycle, decoded from the next state
  always_comb begin
    busy_d       = (state_d == ST_CMD) || (state_d == ST_ADDR) ||
                   (state_d == ST_DUMMY) || (state_d == ST_DATA);
    sclk_d       = busy_d && (phase_d == PH_B);
    flash_cs_d   = !(busy_d && !psram_d);
    psram_cs_d   = !(busy_d && psram_d);
    if (!busy_d) begin
      mosi_d = 1'b0;
    end else if (phase_d == PH_A) begin
      mosi_d = sh_msb_next;
    end else begin
      mosi_d = mosi_q;
    end
    ready_d      = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_DONE);
    resp_err_d   = err_set;
    resp_rdata_d = rd_capture ? sh_rx_next : resp_rdata_q;
  end

  // State, request latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_A;
      cnt_q        <= 6'd0;
      psram_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      sclk_q       <= 1'b0;
      flash_cs_q   <= 1'b1;
      psram_cs_q   <= 1'b1;
      mosi_q       <= 1'b0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      psram_q      <= psram_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sclk_q       <= sclk_d;
      flash_cs_q   <= flash_cs_d;
      psram_cs_q   <= psram_cs_d;
      mosi_q       <= mosi_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready    = ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign sclk_out     = sclk_q;
  assign flash_cs_out = flash_cs_q;
  assign psram_cs_out = psram_cs_q;
  assign mosi_out     = mosi_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: SPI slave model for flash/PSRAM, pin-level
// stream capture, latency and response checks.
`timescale 1ns/1ps
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_psram = 1'b0;
  logic        req_we = 1'b0;
  logic [23:0] req_addr = 24'h000000;
  logic [7:0]  req_wdata = 8'h00;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  logic        sclk_out;
  logic        flash_cs_out;
  logic        psram_cs_out;
  logic        mosi_out;
  logic        miso_in = 1'b0;

  spi_mem_ctrl #(.ADDR_W(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_psram    (req_psram),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .sclk_out     (sclk_out),
    .flash_cs_out (flash_cs_out),
    .psram_cs_out (psram_cs_out),
    .mosi_out     (mosi_out),
    .miso_in      (miso_in)
  );

  always #5 clk = ~clk;

`ifdef SPI_MEM_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int RD_LAT  = FAST ? 97 : 81;
  localparam int RD_BITS = FAST ? 48 : 40;
  localparam int WR_LAT  = 81;
  localparam int WR_BITS = 40;

  int n_cmp = 0;
  int n_fail = 0;
  int sclk_bad = 0;
  int mosi_bad = 0;
  int hi_run = 0;
  int last_gap = 0;
  int last_wait = 0;
  logic prev_mosi = 1'b0;

  logic [7:0] flash_mem [int];
  logic [7:0] psram_mem [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rd_stream(input logic [23:0] a);
    if (FAST) return {16'h0000, 8'h0B, a, 8'h00, 8'h00};
    else      return {24'h000000, 8'h03, a, 8'h00};
  endfunction

  function automatic logic [63:0] wr_stream(input logic [23:0] a, input logic [7:0] d);
    return {24'h000000, 8'h02, a, d};
  endfunction

  // One clock: sample at the falling edge and update the bus-protocol monitors
  task automatic tick();
    @(negedge clk);
    if (flash_cs_out === 1'b1 && psram_cs_out === 1'b1) begin
      if (sclk_out !== 1'b0) sclk_bad++;
      hi_run++;
    end else begin
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
    end
    if (sclk_out === 1'b1 && mosi_out !== prev_mosi) mosi_bad++;
    prev_mosi = mosi_out;
  endtask

  task automatic present(input logic p, input logic w, input logic [23:0] a, input logic [7:0] d);
    req_psram = p;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
  endtask

  task automatic run_txn(input string tag, input logic p, input logic w,
                         input int exp_lat, input logic exp_err, input logic [7:0] exp_rdata,
                         input logic [63:0] exp_stream, input int exp_bits, input bit keep_valid);
    int w_cnt, lat, cs_low, wrong_cs, nbits, dstart, a;
    logic [63:0] stream;
    logic [7:0] src;
    bit got, sel_low, oth_low;
    w_cnt = 0; lat = 0; cs_low = 0; wrong_cs = 0; nbits = 0; a = 0;
    stream = 64'h0; src = 8'hFF; got = 1'b0;
    dstart = (FAST && !w) ? 40 : 32;
    miso_in = 1'b0;
    while (req_ready !== 1'b1 && w_cnt < 8) begin
      tick();
      w_cnt++;
    end
    last_wait = w_cnt;
    check({tag, ".ready"}, req_ready, 1'b1);
    @(posedge clk);
    while (!got && lat < 120) begin
      tick();
      lat++;
      if (lat == 1 && !keep_valid) req_valid = 1'b0;
      sel_low = p ? (psram_cs_out === 1'b0) : (flash_cs_out === 1'b0);
      oth_low = p ? (flash_cs_out === 1'b0) : (psram_cs_out === 1'b0);
      if (sel_low) cs_low++;
      if (oth_low) wrong_cs++;
      if (sel_low && sclk_out === 1'b1) begin
        stream = {stream[62:0], mosi_out};
        nbits++;
      end else if (sel_low && !w) begin
        if (nbits == dstart) begin
          a = FAST ? int'(stream[31:8]) : int'(stream[23:0]);
          if (p) src = psram_mem.exists(a) ? psram_mem[a] : 8'hFF;
          else   src = flash_mem.exists(a) ? flash_mem[a] : 8'hFF;
        end
        if (nbits >= dstart && nbits < dstart + 8) miso_in = src[7 - (nbits - dstart)];
      end
      if (resp_valid === 1'b1) got = 1'b1;
    end
    if (p && w && got) psram_mem[int'(stream[31:8])] = stream[7:0];
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".resp_err"}, resp_err, exp_err);
    check({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, ".cs_low_clks"}, 64'(cs_low), exp_err ? 64'd0 : 64'(exp_lat - 1));
    check({tag, ".other_cs"}, 64'(wrong_cs), 64'd0);
    check({tag, ".mosi_bits"}, 64'(nbits), 64'(exp_bits));
    check({tag, ".mosi_stream"}, stream, exp_stream);
  endtask

  initial begin
    int rv_cnt;
    flash_mem[32'h000010] = 8'hA5;
    flash_mem[32'h000020] = 8'h5A;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst.sclk", sclk_out, 1'b0);
    check("rst.flash_cs", flash_cs_out, 1'b1);
    check("rst.psram_cs", psram_cs_out, 1'b1);
    check("rst.mosi", mosi_out, 1'b0);
    check("rst.ready", req_ready, 1'b1);
    check("rst.resp_valid", resp_valid, 1'b0);
    check("rst.resp_rdata", resp_rdata, 8'h00);
    check("rst.resp_err", resp_err, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle.ready", req_ready, 1'b1);

    // Flash read
    present(1'b0, 1'b0, 24'h000010, 8'h00);
    run_txn("flash_rd", 1'b0, 1'b0, RD_LAT, 1'b0, 8'hA5, rd_stream(24'h000010), RD_BITS, 1'b0);
    tick();
    check("flash_rd.pulse", resp_valid, 1'b0);
    check("flash_rd.hold", resp_rdata, 8'hA5);

    // PSRAM write then read back
    present(1'b1, 1'b1, 24'h123456, 8'h3C);
    run_txn("psram_wr", 1'b1, 1'b1, WR_LAT, 1'b0, 8'hA5, wr_stream(24'h123456, 8'h3C), WR_BITS, 1'b0);
    present(1'b1, 1'b0, 24'h123456, 8'h00);
    run_txn("psram_rd", 1'b1, 1'b0, RD_LAT, 1'b0, 8'h3C, rd_stream(24'h123456), RD_BITS, 1'b0);

    // Flash write is rejected without bus activity
    present(1'b0, 1'b1, 24'h000000, 8'h99);
    run_txn("flash_wr", 1'b0, 1'b1, 1, 1'b1, 8'h3C, 64'h0, 0, 1'b0);
    tick();
    check("flash_wr.err_clear", resp_err, 1'b0);

    // Back-to-back with req_valid held high
    present(1'b1, 1'b1, 24'h000200, 8'h77);
    run_txn("b2b_1", 1'b1, 1'b1, WR_LAT, 1'b0, 8'h3C, wr_stream(24'h000200, 8'h77), WR_BITS, 1'b1);
    present(1'b0, 1'b0, 24'h000020, 8'h00);
    run_txn("b2b_2", 1'b0, 1'b0, RD_LAT, 1'b0, 8'h5A, rd_stream(24'h000020), RD_BITS, 1'b0);
    check("b2b.accept_cycle82", 64'(last_wait), 64'd1);
    check("b2b.cs_gap_ge2", 64'(last_gap >= 2), 64'd1);

    // Reset in the middle of a PSRAM read
    tick();
    rv_cnt = 0;
    present(1'b1, 1'b0, 24'h123456, 8'h00);
    check("rstmid.ready", req_ready, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      if (resp_valid === 1'b1) rv_cnt++;
    end
    check("rstmid.cs_active", psram_cs_out, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstmid.psram_cs", psram_cs_out, 1'b1);
    check("rstmid.flash_cs", flash_cs_out, 1'b1);
    check("rstmid.sclk", sclk_out, 1'b0);
    check("rstmid.mosi", mosi_out, 1'b0);
    check("rstmid.ready", req_ready, 1'b1);
    check("rstmid.rdata", resp_rdata, 8'h00);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (resp_valid === 1'b1) rv_cnt++;
    end
    check("rstmid.no_resp", 64'(rv_cnt), 64'd0);
    present(1'b1, 1'b0, 24'h123456, 8'h00);
    run_txn("after_rst", 1'b1, 1'b0, RD_LAT, 1'b0, 8'h3C, rd_stream(24'h123456), RD_BITS, 1'b0);

    // Protocol monitors over the whole run
    check("sclk_while_cs_high", 64'(sclk_bad), 64'd0);
    check("mosi_change_phase_b", 64'(mosi_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

Single-channel SPI master that serves byte-wide memory requests from the tiny CPU core to an external SPI flash (read-only program store) and SPI PSRAM (read/write data store). It sits between the CPU's memory request port and the chip pins (SCLK, flash CS, PSRAM CS, MOSI, MISO). It sequences command, 24-bit address and one data byte per transaction in SPI mode 0 at half the system clock rate.

## Interface
Parameters:
- ADDR_W, default 24, width of byte address sent on the bus.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  high only in IDLE; request accepted on a clk edge where req_valid && req_ready.
- req_psram  in  1  1 = PSRAM, 0 = flash.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  8  write byte.
- resp_valid  out  1  one-cycle pulse on completion.
- resp_rdata  out  8  read byte; held until next completion.
- resp_err  out  1  valid with resp_valid; 1 = flash write rejected.
- sclk_out  out  1  SPI clock, idle low.
- flash_cs_out  out  1  flash chip select, active low.
- psram_cs_out  out  1  PSRAM chip select, active low.
- mosi_out  out  1  serial data out, MSB first.
- miso_in  in  1  serial data in.

## Operation
- States: IDLE, CMD, ADDR, (DUMMY), DATA, DONE.
- IDLE: req_ready=1, both CS high, sclk 0. Accept latches psram/we/addr/wdata.
- Flash write (req_psram=0, req_we=1): no pin activity; go to DONE with resp_err=1.
- CMD: 8 bits; read 0x03, write 0x02. ADDR: ADDR_W bits MSB first. DATA: 8 bits; write shifts req_wdata out, read shifts miso in.
- Selected CS low from first CMD cycle through last DATA cycle; unselected CS stays high.
- Each SPI bit = 2 clks: phase A sclk=0 with mosi driving bit; phase B sclk=1. miso sampled at the clk edge ending phase B.
- DONE: 1 cycle, both CS high, sclk 0, resp_valid=1, resp_rdata updated for reads (unchanged for writes and errors). Then IDLE.
- Bit counter 6 bits, counts down within each state; transitions when it reaches 0 in phase B.
- req_valid while busy is ignored (ready low); the CPU holds the request.

## Timing
- Reset values: sclk_out 0, flash_cs_out 1, psram_cs_out 1, mosi_out 0, req_ready 1, resp_valid 0, resp_rdata 0x00, resp_err 0, state IDLE.
- Accept at edge 0. CS low in cycles 1..80 (40 bits × 2). DONE in cycle 81. req_ready high again from cycle 82. Latency is 81 cycles to resp_valid.
- Flash write: DONE in cycle 1, resp_valid/resp_err in cycle 1.
- Back-to-back: CS is high for at least the DONE cycle plus the IDLE accept cycle (2 clks) between transactions.
- Reset asserted mid-transaction: all outputs return immediately to reset values (CS high, sclk low). No resp_valid is produced and the partial transaction is abandoned.
- All pin outputs are registered. mosi changes only in phase A.

## Configuration
- SPI_MEM_FAST_READ_EN defined: reads use command 0x0B followed by DUMMY state of 8 bits (16 clks). Read latency is 97 cycles (CS low cycles 1..96). Writes are unchanged.
- Not defined: DUMMY state is absent; reads use 0x03; latency is 81 cycles.

## Structure
- tiny_mcu_pkg: state enum, command constants (CMD_READ=0x03, CMD_FAST_READ=0x0B, CMD_WRITE=0x02), DUMMY_BITS=8, DATA_BITS=8.
- One sub-module, spi_mem_shifter: 8-bit shift register with load, shift-out on phase A and sample-in on phase B. The controller FSM owns the counter and chip selects.

## Test plan
- Flash read, addr 0x000010, model returns 0xA5 → flash_cs low for 80 clks, MOSI stream 0x03,0x00,0x00,0x10; resp_valid at cycle 81, resp_rdata=0xA5, resp_err=0; psram_cs stays high.
- PSRAM write 0x3C to 0x123456 then read it back → MOSI 0x02,0x12,0x34,0x56,0x3C on psram_cs; read returns 0x3C.
- Flash write to 0x000000 → no CS or SCLK toggle; resp_valid and resp_err=1 at cycle 1; resp_rdata unchanged.
- Two requests back-to-back with req_valid held high → second accepted at cycle 82; CS high for ≥2 clks between transactions; SCLK never toggles while CS is high.
- rst_n pulsed low at cycle 40 of a PSRAM read → CS high and sclk 0 immediately, no resp_valid; the next request completes normally.
- With SPI_MEM_FAST_READ_EN: flash read → command 0x0B, 8 dummy bits, resp_valid at cycle 97 with correct data.
